// File: rtl/mfp_7seg_scan_ctrl.sv
// Scan scheduler for an N-digit active-low 7-segment display with blanking dead-time.
// Latency: one cycle from a state change to the pins; new digit data takes effect at the next frame boundary.
// No backpressure: LOAD is always accepted, and the last LOAD before a boundary wins.
//
// Ports:
//   HCLK, HRESET         clock, synchronous active-high reset
//   LOAD                 1-cycle strobe capturing DIGITS/EN_MASK/DP_MASK into the pending buffer
//   DIGITS               hex nibble per digit, digit i = DIGITS[4i+3:4i]
//   EN_MASK, DP_MASK     per-digit scan enable, per-digit decimal point
//   IO_7SEGEN_N          digit anodes, active-low
//   IO_7SEG_N            segments {CA..CG}, active-low
//   IO_DP_N              decimal point, active-low
//   FRAME_DONE           1-cycle pulse in the first cycle after each frame boundary
module mfp_7seg_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 64,
  parameter int CNT_W        = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    LOAD,
  input  logic [4*N_DIGITS-1:0]   DIGITS,
  input  logic [N_DIGITS-1:0]     EN_MASK,
  input  logic [N_DIGITS-1:0]     DP_MASK,
  output logic [N_DIGITS-1:0]     IO_7SEGEN_N,
  output logic [6:0]              IO_7SEG_N,
  output logic                    IO_DP_N,
  output logic                    FRAME_DONE
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [4*N_DIGITS-1:0]   pend_dig_q, act_dig_q;
  logic [N_DIGITS-1:0]     pend_en_q, pend_dp_q, act_en_q, act_dp_q;
  logic                    pend_vld_q;

  logic                    apply;
  logic                    frame_end;
  logic [N_DIGITS-1:0]     new_en;
  logic [IDX_W:0]          nxt;

  logic [N_DIGITS-1:0]     an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_DIGITS-1:0] en);
    lowest_set = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (en[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // {found, index} of the lowest enabled digit strictly above cur.
  function automatic logic [IDX_W:0] next_above(input logic [N_DIGITS-1:0] en,
                                                input logic [IDX_W-1:0]  cur);
    next_above = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (en[i] && (i > int'(cur))) next_above = {1'b1, IDX_W'(i)};
    end
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'b0000001;
      4'h1: hex_seg = 7'b1001111;
      4'h2: hex_seg = 7'b0010010;
      4'h3: hex_seg = 7'b0000110;
      4'h4: hex_seg = 7'b1001100;
      4'h5: hex_seg = 7'b0100100;
      4'h6: hex_seg = 7'b0100000;
      4'h7: hex_seg = 7'b0001111;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0000100;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b1100000;
      4'hC: hex_seg = 7'b0110001;
      4'hD: hex_seg = 7'b1000010;
      4'hE: hex_seg = 7'b0110000;
      default: hex_seg = 7'b0111000;
    endcase
  endfunction

  // State register plus the pending/active data buffers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_dig_q <= '0;
      pend_en_q  <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      act_dig_q  <= '0;
      act_en_q   <= '0;
      act_dp_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (apply) begin
        act_dig_q <= pend_dig_q;
        act_en_q  <= pend_en_q;
        act_dp_q  <= pend_dp_q;
      end
      // A LOAD coinciding with an apply refills the buffer for the following boundary.
      if (LOAD) begin
        pend_dig_q <= DIGITS;
        pend_en_q  <= EN_MASK;
        pend_dp_q  <= DP_MASK;
        pend_vld_q <= 1'b1;
      end else if (apply) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    apply     = 1'b0;
    frame_end = 1'b0;
    new_en    = pend_vld_q ? pend_en_q : act_en_q;
    nxt       = next_above(act_en_q, idx_q);
    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          apply = 1'b1;
          if (pend_en_q != '0) begin
            state_d = ST_BLANK;
            idx_d   = lowest_set(pend_en_q);
            cnt_d   = '0;
          end
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d = '0;
          if (nxt[IDX_W]) begin
            state_d = ST_BLANK;
            idx_d   = nxt[IDX_W-1:0];
          end else begin
            // Wrap (or single enabled digit): frame boundary.
            frame_end = 1'b1;
            apply     = pend_vld_q;
            if (new_en == '0) begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end else begin
              state_d = ST_BLANK;
              idx_d   = lowest_set(new_en);
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the pins change in the first cycle of that state.
  // Entering ON never coincides with an apply, so the active buffer is already current.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == ST_ON) begin
      an_d[idx_d] = 1'b0;
      seg_d       = hex_seg(act_dig_q[4*idx_d +: 4]);
      dp_d        = ~act_dp_q[idx_d];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      IO_7SEGEN_N <= '1;
      IO_7SEG_N   <= 7'h7F;
      IO_DP_N     <= 1'b1;
      FRAME_DONE  <= 1'b0;
    end else begin
      IO_7SEGEN_N <= an_d;
      IO_7SEG_N   <= seg_d;
      IO_DP_N     <= dp_d;
      FRAME_DONE  <= frame_end;
    end
  end

endmodule

// File: tb/tb_mfp_7seg_scan_ctrl.sv
// Self-checking bench for mfp_7seg_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
// The reference model tracks a time offset within the frame and derives slot/phase arithmetically.
// Directed scenarios pin absolute values, then a randomized run is compared every cycle.
module tb_mfp_7seg_scan_ctrl;

  localparam int N  = 8;
  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        hreset;
  logic        load;
  logic [31:0] digits;
  logic [7:0]  en_mask;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  always #5 clk = ~clk;

  mfp_7seg_scan_ctrl #(
    .N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .CNT_W(16)
  ) dut (
    .HCLK(clk), .HRESET(hreset), .LOAD(load), .DIGITS(digits),
    .EN_MASK(en_mask), .DP_MASK(dp_mask), .IO_7SEGEN_N(an),
    .IO_7SEG_N(seg), .IO_DP_N(dp_n), .FRAME_DONE(frame_done)
  );

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model state
  logic        m_run;
  int          m_t;
  logic [31:0] m_adig, m_pdig;
  logic [7:0]  m_aen, m_adp, m_pen, m_pdp;
  logic        m_pvld;
  logic        m_fd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fd = -1;
  int fd_period = 0;
  int fd_count = 0;

  logic [7:0] obs_an;
  logic [6:0] obs_seg;
  logic       obs_dp, obs_fd;

  function automatic int popcnt(input logic [7:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int nth_bit(input logic [7:0] v, input int k);
    int c;
    int r;
    c = 0;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        if (c == k) r = i;
        c++;
      end
    end
    return r;
  endfunction

  task automatic model_apply();
    m_adig = m_pdig;
    m_aen  = m_pen;
    m_adp  = m_pdp;
    m_pvld = 1'b0;
  endtask

  task automatic model_step();
    if (hreset) begin
      m_run = 1'b0; m_t = 0; m_fd = 1'b0; m_pvld = 1'b0;
      m_adig = '0; m_aen = '0; m_adp = '0;
      m_pdig = '0; m_pen = '0; m_pdp = '0;
    end else begin
      m_fd = 1'b0;
      if (!m_run) begin
        if (m_pvld) begin
          model_apply();
          if (m_aen != 0) begin
            m_run = 1'b1;
            m_t   = 0;
          end
        end
      end else begin
        m_t++;
        if (m_t == popcnt(m_aen) * SD) begin
          m_fd = 1'b1;
          m_t  = 0;
          if (m_pvld) model_apply();
          if (m_aen == 0) m_run = 1'b0;
        end
      end
      if (load) begin
        m_pdig = digits; m_pen = en_mask; m_pdp = dp_mask; m_pvld = 1'b1;
      end
    end
  endtask

  task automatic check_cycle();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int d;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_run && ((m_t % SD) >= BL)) begin
      d = nth_bit(m_aen, m_t / SD);
      e_an = ~(8'h01 << d);
      e_seg = hex_tab[m_adig[4*d +: 4]];
      e_dp = ~m_adp[d];
    end
    obs_an = an; obs_seg = seg; obs_dp = dp_n; obs_fd = frame_done;
    checks++;
    if ({obs_an, obs_seg, obs_dp, obs_fd} !== {e_an, e_seg, e_dp, m_fd}) begin
      errors++;
      $display("FAIL outputs cyc=%0d got an=%h seg=%b dp=%b fd=%b want an=%h seg=%b dp=%b fd=%b",
               cyc, obs_an, obs_seg, obs_dp, obs_fd, e_an, e_seg, e_dp, m_fd);
    end
    if (obs_fd === 1'b1) begin
      fd_count++;
      if (last_fd >= 0) fd_period = cyc - last_fd;
      last_fd = cyc;
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [31:0] d,
                      input logic [7:0] en, input logic [7:0] dp);
    hreset = rst; load = ld; digits = d; en_mask = en; dp_mask = dp;
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, digits, en_mask, dp_mask);
  endtask

  task automatic wait_fd(input int max);
    int k;
    k = 0;
    do begin
      idle(1);
      k++;
    end while (obs_fd !== 1'b1 && k < max);
    checks++;
    if (obs_fd !== 1'b1) begin
      errors++;
      $display("FAIL wait_fd timeout after %0d cycles", k);
    end
  endtask

  initial begin
    int l_cyc, bad, on, fd0;
    logic seen_fe, seen_df;
    logic rst_r, ld_r;
    logic [7:0] en_r;
    hreset = 1'b1; load = 1'b0; digits = '0; en_mask = '0; dp_mask = '0;
    @(negedge clk);

    // 1: reset then idle
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, '0, '0);
    check_val("t1_rst_an", an, 8'hFF);
    check_val("t1_rst_seg", seg, 7'h7F);
    check_val("t1_rst_dp", dp_n, 1);
    check_val("t1_rst_fd", frame_done, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if ({obs_an, obs_seg, obs_dp, obs_fd} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) bad++;
    end
    check_val("t1_idle_blank", bad, 0);

    // 2: full frame, all digits
    step(1'b0, 1'b1, 32'h76543210, 8'hFF, 8'h01);
    l_cyc = cyc;
    idle(2);
    check_val("t2_blank_an", obs_an, 8'hFF);
    idle(1);
    check_val("t2_d0_an", obs_an, 8'hFE);
    check_val("t2_d0_seg", obs_seg, 7'b0000001);
    check_val("t2_d0_dp", obs_dp, 0);
    idle(5);
    idle(2);
    check_val("t2_blank2_an", obs_an, 8'hFF);
    idle(1);
    check_val("t2_d1_an", obs_an, 8'hFD);
    check_val("t2_d1_seg", obs_seg, 7'b1001111);
    check_val("t2_d1_dp", obs_dp, 1);
    wait_fd(100);
    check_val("t2_first_fd", last_fd - l_cyc, 65);
    idle(200);
    check_val("t2_fd_period", fd_period, 64);

    // 3: sparse enable masks
    step(1'b0, 1'b1, 32'h76543210, 8'b0010_0001, 8'h00);
    idle(300);
    check_val("t3_fd_period_21", fd_period, 16);
    bad = 0; seen_fe = 1'b0; seen_df = 1'b0;
    for (int i = 0; i < 64; i++) begin
      idle(1);
      if (!(obs_an inside {8'hFE, 8'hDF, 8'hFF})) bad++;
      if (obs_an == 8'hFE) seen_fe = 1'b1;
      if (obs_an == 8'hDF) seen_df = 1'b1;
    end
    check_val("t3_only_d0_d5", bad, 0);
    check_val("t3_seen_both", {seen_fe, seen_df}, 2'b11);
    step(1'b0, 1'b1, 32'h76543210, 8'h01, 8'h00);
    idle(100);
    check_val("t3_fd_period_01", fd_period, 8);

    // 4: two mid-frame LOADs, last one wins at the boundary
    step(1'b0, 1'b1, 32'h76543210, 8'hFF, 8'h00);
    wait_fd(100);
    wait_fd(100);
    idle(10);
    step(1'b0, 1'b1, 32'hFFFFFFFF, 8'hFF, 8'h00);
    idle(3);
    step(1'b0, 1'b1, 32'h88888888, 8'hFF, 8'h00);
    wait_fd(100);
    bad = 0; on = 0;
    for (int i = 0; i < 64; i++) begin
      idle(1);
      if (obs_an != 8'hFF) begin
        on++;
        if (obs_seg != 7'b0000000) bad++;
      end
    end
    check_val("t4_on_cycles", on, 48);
    check_val("t4_all_eights", bad, 0);

    // 5: EN=00 stops after the frame, EN=FF restarts at digit 0
    wait_fd(100);
    idle(10);
    step(1'b0, 1'b1, 32'h76543210, 8'h00, 8'h00);
    wait_fd(100);
    bad = 0; fd0 = fd_count;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (obs_an != 8'hFF) bad++;
    end
    check_val("t5_idle_an", bad, 0);
    check_val("t5_idle_no_fd", fd_count - fd0, 0);
    step(1'b0, 1'b1, 32'h76543210, 8'hFF, 8'h01);
    idle(3);
    check_val("t5_restart_an", obs_an, 8'hFE);
    check_val("t5_restart_seg", obs_seg, 7'b0000001);
    check_val("t5_restart_dp", obs_dp, 0);

    // 6: reset mid-slot with pending data
    idle(2);
    check_val("t6_on_an", obs_an, 8'hFE);
    step(1'b0, 1'b1, 32'h12345678, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, digits, en_mask, dp_mask);
    check_val("t6_rst_an", obs_an, 8'hFF);
    check_val("t6_rst_seg", obs_seg, 7'h7F);
    bad = 0; fd0 = fd_count;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (obs_an != 8'hFF) bad++;
    end
    check_val("t6_stays_idle", bad, 0);
    check_val("t6_no_fd", fd_count - fd0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_r = ($urandom_range(0, 399) == 0);
      ld_r  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 7))
        0: en_r = 8'h00;
        1: en_r = 8'h01 << $urandom_range(0, 7);
        default: en_r = 8'($urandom);
      endcase
      step(rst_r, ld_r, $urandom, en_r, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
